// File: rtl/shared_reg_arbiter_if.sv
// Bus bundle between control sources and the shared-register arbiter.
// The lock vector exists only when ARB_LOCK_EN is defined.
interface shared_reg_arbiter_if #(
  parameter int N = 8,
  parameter int R = 4
) ();
  logic [R-1:0]   req;
  logic [R*N-1:0] data_in;
`ifdef ARB_LOCK_EN
  logic [R-1:0]   lock;
`endif
  logic           reg_en;
  logic [N-1:0]   reg_d;
  logic [R-1:0]   grant;
  logic [R-1:0]   ack;
  logic           busy;

  modport master (
    output req, data_in,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    input  reg_en, reg_d, grant, ack, busy
  );

  modport slave (
    input  req, data_in,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    output reg_en, reg_d, grant, ack, busy
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared enable-gated register.
// Optional macro ARB_LOCK_EN adds locked back-to-back bursts of up to MAX_LOCK writes.
module shared_reg_arbiter #(
  parameter int N = 8,
  parameter int R = 4
`ifdef ARB_LOCK_EN
  , parameter int MAX_LOCK = 4
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  shared_reg_arbiter_if.slave   bus
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [R-1:0]    grant_q, grant_d;
  logic [R-1:0]    ack_q, ack_d;
  logic [N-1:0]    reg_d_q, reg_d_d;
  logic            reg_en_q, reg_en_d;
  logic            busy_q, busy_d;
  logic [IW:0]     pick;

`ifdef ARB_LOCK_EN
  localparam int LW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            relock;
`endif

  // Returns {found, index} of the first set request at or after ptr, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [R-1:0] rq, input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int k = R - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= R) j = j - R;
      if (rq[j]) res = {1'b1, IW'(j)};
    end
    return res;
  endfunction

  always_comb begin
    pick = rr_pick(bus.req, rr_ptr_q);
  end

`ifdef ARB_LOCK_EN
  always_comb begin
    relock = bus.lock[gidx_q] && bus.req[gidx_q] && (lock_cnt_q < LW'(MAX_LOCK - 1));
  end
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    reg_d_d  = reg_d_q;
    reg_en_d = 1'b0;
    ack_d    = '0;
`ifdef ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick[IW]) begin
          gidx_d          = pick[IW-1:0];
          grant_d         = '0;
          grant_d[pick[IW-1:0]] = 1'b1;
          reg_d_d         = bus.data_in[pick[IW-1:0]*N +: N];
          reg_en_d        = 1'b1;
          state_d         = GRANT;
        end
      end
      GRANT: begin
        ack_d   = grant_q;
        state_d = ACK;
      end
      ACK: begin
`ifdef ARB_LOCK_EN
        if (relock) begin
          reg_d_d    = bus.data_in[gidx_q*N +: N];
          reg_en_d   = 1'b1;
          lock_cnt_d = lock_cnt_q + 1'b1;
          state_d    = GRANT;
        end else begin
          lock_cnt_d = '0;
`endif
          grant_d  = '0;
          rr_ptr_d = (gidx_q == IW'(R - 1)) ? '0 : gidx_q + 1'b1;
          state_d  = IDLE;
`ifdef ARB_LOCK_EN
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Every output is registered; reset clears them in the cycle after it is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      reg_d_q  <= '0;
      reg_en_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      reg_d_q  <= reg_d_d;
      reg_en_q <= reg_en_d;
      busy_q   <= busy_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign bus.reg_en = reg_en_q;
  assign bus.reg_d  = reg_d_q;
  assign bus.grant  = grant_q;
  assign bus.ack    = ack_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: ack-driven scoreboard plus cycle-exact checks.
module tb_shared_reg_arbiter;
  localparam int N = 8;
  localparam int R = 4;

  typedef struct {
    int         idx;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] q;
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  shared_reg_arbiter_if #(.N(N), .R(R)) bif ();

  shared_reg_arbiter #(.N(N), .R(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Model of the shared register the arbiter feeds.
  always @(posedge clk) begin
    if (reset) q <= '0;
    else if (bif.reg_en) q <= bif.reg_d;
  end

  function automatic logic [R-1:0] oh(input int i);
    logic [R-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every ack pops one expected write and checks owner and stored value.
  always @(negedge clk) begin
    exp_t e;
    if (bif.ack != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {28'd0, bif.ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_ack_owner", {28'd0, bif.ack}, {28'd0, oh(e.idx)});
        chk("sb_grant_at_ack", {28'd0, bif.grant}, {28'd0, oh(e.idx)});
        chk("sb_q_data", {24'd0, q}, {24'd0, e.d});
      end
    end
    if (($countones(bif.grant) > 1) || ($countones(bif.ack) > 1) ||
        (bif.reg_en && ($countones(bif.grant) != 1))) begin
      chk("onehot_invariant", {28'd0, bif.grant}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bif.req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    bif.data_in[i*N +: N] = d;
  endtask

  // One full write from IDLE for requester w, which drops req on ack.
  task automatic do_cycle(input int w, input logic [7:0] d);
    sb.push_back('{w, d});
    tick();
    chk("grant", {28'd0, bif.grant}, {28'd0, oh(w)});
    chk("reg_en_on_grant", {31'd0, bif.reg_en}, 32'd1);
    chk("reg_d", {24'd0, bif.reg_d}, {24'd0, d});
    tick();
    chk("ack", {28'd0, bif.ack}, {28'd0, oh(w)});
    chk("reg_en_off_ack", {31'd0, bif.reg_en}, 32'd0);
    bif.req[w] = 1'b0;
    tick();
    chk("busy_idle", {31'd0, bif.busy}, 32'd0);
    chk("grant_idle", {28'd0, bif.grant}, 32'd0);
  endtask

  initial begin
    bif.req = '0;
    bif.data_in = '0;
`ifdef ARB_LOCK_EN
    bif.lock = '0;
`endif
    do_reset();
    chk("rst_grant", {28'd0, bif.grant}, 32'd0);
    chk("rst_ack", {28'd0, bif.ack}, 32'd0);
    chk("rst_reg_en", {31'd0, bif.reg_en}, 32'd0);
    chk("rst_reg_d", {24'd0, bif.reg_d}, 32'd0);
    chk("rst_busy", {31'd0, bif.busy}, 32'd0);

    // Single write, latency and busy
    set_data(1, 8'hA5);
    bif.req = 4'b0010;
    do_cycle(1, 8'hA5);

    // All four requesting from pointer 0
    do_reset();
    for (int i = 0; i < R; i++) set_data(i, 8'h10 + 8'(i));
    bif.req = 4'b1111;
    for (int i = 0; i < R; i++) do_cycle(i, 8'h10 + 8'(i));

    // Wrap: requester 2 writes, then 3 precedes 0
    do_reset();
    set_data(2, 8'h22);
    bif.req = 4'b0100;
    do_cycle(2, 8'h22);
    set_data(3, 8'h33);
    set_data(0, 8'h30);
    bif.req = 4'b1001;
    do_cycle(3, 8'h33);
    do_cycle(0, 8'h30);

    // Data latched at grant, req dropped during GRANT
    set_data(0, 8'h3C);
    bif.req = 4'b0001;
    sb.push_back('{0, 8'h3C});
    tick();
    chk("t4_grant", {28'd0, bif.grant}, 32'h1);
    set_data(0, 8'hFF);
    bif.req = '0;
    tick();
    chk("t4_ack", {28'd0, bif.ack}, 32'h1);
    tick();
    chk("t4_q_hold", {24'd0, q}, 32'h3C);

    // Reset during GRANT abandons the write
    set_data(0, 8'h77);
    bif.req = 4'b0001;
    tick();
    chk("t5_in_grant", {31'd0, bif.reg_en}, 32'd1);
    reset = 1'b1;
    bif.req = '0;
    tick();
    reset = 1'b0;
    chk("t5_grant", {28'd0, bif.grant}, 32'd0);
    chk("t5_reg_en", {31'd0, bif.reg_en}, 32'd0);
    chk("t5_reg_d", {24'd0, bif.reg_d}, 32'd0);
    chk("t5_busy", {31'd0, bif.busy}, 32'd0);
    tick();
    chk("t5_no_ack", {28'd0, bif.ack}, 32'd0);
    chk("t5_q", {24'd0, q}, 32'd0);
    set_data(0, 8'h55);
    set_data(2, 8'h44);
    bif.req = 4'b0101;
    do_cycle(0, 8'h55);
    do_cycle(2, 8'h44);

`ifdef ARB_LOCK_EN
    // Locked burst by requester 1, then requester 0
    do_reset();
    set_data(0, 8'h61);
    bif.req = 4'b0001;
    do_cycle(0, 8'h61);
    set_data(1, 8'h50);
    set_data(0, 8'h60);
    bif.lock = 4'b0010;
    bif.req = 4'b0011;
    sb.push_back('{1, 8'h50});
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("lk_grant", {28'd0, bif.grant}, 32'h2);
      chk("lk_reg_en", {31'd0, bif.reg_en}, 32'd1);
      chk("lk_reg_d", {24'd0, bif.reg_d}, {24'd0, 8'h50 + 8'(k)});
      tick();
      chk("lk_ack", {28'd0, bif.ack}, 32'h2);
      if (k < 3) begin
        set_data(1, 8'h51 + 8'(k));
        sb.push_back('{1, 8'h51 + 8'(k)});
      end else begin
        bif.req[1] = 1'b0;
        bif.lock = '0;
      end
      tick();
    end
    chk("lk_release_busy", {31'd0, bif.busy}, 32'd0);
    sb.push_back('{0, 8'h60});
    tick();
    chk("lk_next_grant", {28'd0, bif.grant}, 32'h1);
    tick();
    bif.req = '0;
    tick();
`endif

    tick();
    tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
